// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared constants for the 3-digit 7-segment scan controller.
//            Provides the segment glyphs, the one-hot digit enables and the
//            scan FSM state type.
// Contents : SEG_0..SEG_F, SEG_OFF  - glyphs as {g,f,e,d,c,b,a}, active high
//            DIG2, DIG1, DIG0       - one-hot anode enables
//            scan_state_t           - {BLANK, DRIVE}
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Glyphs as {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // One-hot digit enables, digit 2 is the leftmost
    localparam logic [2:0] DIG2 = 3'b100;
    localparam logic [2:0] DIG1 = 3'b010;
    localparam logic [2:0] DIG0 = 3'b001;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational hex nibble to 7-segment glyph decoder.
//            0-9 use the usual glyphs, A-F render as A, b, C, d, E, F.
// Ports    : i_nib [3:0]  - nibble to display
//            o_seg [6:0]  - segments {g,f,e,d,c,b,a}, active high
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Time-multiplexed scan controller for three 7-segment digits.
//            A 12-bit value is written through a valid/ready port into a
//            shadow register and committed to the display register only at
//            the end of a frame, so a frame never shows a mix of values.
//            Each digit slot opens with a blanking gap (all anodes off) to
//            suppress ghosting; leading zeros can optionally be blanked.
// Ports    : clk            - system clock
//            rst            - synchronous active-high reset
//            wr_valid       - new display value offered
//            wr_data [11:0] - {digit2, digit1, digit0} nibbles
//            wr_ready       - shadow register empty
//            blank_lz       - 1 = suppress leading zeros (sampled per slot)
//            an [2:0]       - one-hot anode enables, an[2] = digit 2
//            seg [6:0]      - segments {g,f,e,d,c,b,a}, active high
//            frame_done     - pulse on the last cycle of the digit-0 slot
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_HZ    = 27_000_000,
    parameter int SCAN_HZ   = 500,
    parameter int BLANK_CYC = 270
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    input  logic        blank_lz,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int SLOT_CYC = CLK_HZ / (2 * SCAN_HZ);
    localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    generate
        if (BLANK_CYC < 1 || BLANK_CYC >= SLOT_CYC) begin : g_bad_blank_cyc
            $fatal(1, "display_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < SLOT_CYC");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_digit;
    logic [2:0]       w_digit_next;
    logic             w_wrap;
    logic             w_frame_end;

    // Shadow / display registers
    logic [11:0] r_shadow;
    logic        r_shadow_full;
    logic [11:0] r_disp;
    logic [11:0] w_disp_next;
    logic        w_accept;
    logic        w_commit;
    logic        w_full_next;
    logic        r_wr_ready;

    // Output registers and their next values
    logic [2:0] r_an;
    logic [6:0] r_seg;
    logic       r_frame_done;
    logic       r_seg_init;
    logic [2:0] w_an_next;
    logic [6:0] w_seg_next;
    logic       w_fd_next;
    logic       w_seg_load;
    logic [3:0] w_nib;
    logic [6:0] w_dec_seg;
    logic       w_lead_zero;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_digit <= DIG2;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_digit <= w_digit_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_wrap       = (r_cnt == CNT_LAST);
        w_frame_end  = w_wrap && (r_digit == DIG0);
        w_cnt_next   = w_wrap ? '0 : r_cnt + 1'b1;
        // Rotate right: digit 2 -> 1 -> 0 -> 2
        w_digit_next = w_wrap ? {r_digit[0], r_digit[2:1]} : r_digit;
        w_state_next = r_state;
        case (r_state)
            BLANK:   if (w_cnt_next == CNT_BLANK) w_state_next = DRIVE;
            DRIVE:   if (w_wrap)                  w_state_next = BLANK;
            default: w_state_next = BLANK;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Outputs are registered, so they are derived from
    // the next state to stay aligned with the counter value they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_an_next = (w_state_next == DRIVE) ? w_digit_next : 3'b000;
        w_fd_next = (w_cnt_next == CNT_LAST) && (w_digit_next == DIG0);
    end

    // ------------------------------------------------------------------
    // Write handshake and frame-boundary commit
    // ------------------------------------------------------------------
    always_comb begin
        w_accept    = wr_valid & r_wr_ready;
        w_commit    = w_frame_end & r_shadow_full;
        // A write landing on the commit edge refills the shadow afterwards
        w_full_next = w_accept | (r_shadow_full & ~w_commit);
        w_disp_next = w_commit ? r_shadow : r_disp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_disp        <= '0;
            r_wr_ready    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow <= wr_data;
            end
            r_shadow_full <= w_full_next;
            r_disp        <= w_disp_next;
            r_wr_ready    <= ~w_full_next;
        end
    end

    // ------------------------------------------------------------------
    // Segment pattern for the slot about to start. The pattern is loaded
    // on the slot-start edge (and once after reset for the first slot) so
    // seg is already settled through the blanking gap.
    // ------------------------------------------------------------------
    always_comb begin
        w_seg_load = w_wrap | r_seg_init;
        case (w_digit_next)
            DIG2:    w_nib = w_disp_next[11:8];
            DIG1:    w_nib = w_disp_next[7:4];
            default: w_nib = w_disp_next[3:0];
        endcase
        w_lead_zero = blank_lz &&
                      (((w_digit_next == DIG2) && (w_disp_next[11:8] == 4'h0)) ||
                       ((w_digit_next == DIG1) && (w_disp_next[11:4] == 8'h00)));
        w_seg_next = r_seg;
        if (w_seg_load) begin
            w_seg_next = w_lead_zero ? SEG_OFF : w_dec_seg;
        end
    end

    seg7_decoder u_seg7_decoder (
        .i_nib (w_nib),
        .o_seg (w_dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= 3'b000;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
            r_seg_init   <= 1'b1;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_frame_done <= w_fd_next;
            r_seg_init   <= 1'b0;
        end
    end

    assign wr_ready   = r_wr_ready;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule : display_scan_ctrl
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Self-checking bench for display_scan_ctrl (SLOT_CYC=10,
//            BLANK_CYC=2). A frame-level reference model predicts every
//            output on every cycle; directed sequences and a vector table
//            cover commit timing, stalls, leading-zero blanking and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 50;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = 10;
    localparam int FRAME     = 3 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_data = 12'h000;
    logic        blank_lz = 1'b0;
    logic        wr_ready;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Digit k (2 = leftmost) is a leading zero when it and everything to its
    // left is zero; the rightmost digit is always shown.
    function automatic logic [6:0] model_seg(input logic [11:0] v, input int k, input logic lz);
        if (lz && k > 0 && (v >> (4 * k)) == 12'h000) return 7'h00;
        return glyph(v[4*k +: 4]);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: m_t counts cycles since the last reset edge; frame
    // position is plain modular arithmetic on it.
    // ------------------------------------------------------------------
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic        m_ready  = 1'b0;
    logic        m_full   = 1'b0;
    logic        m_lz     = 1'b0;
    logic [11:0] m_disp   = 12'h000;
    logic [11:0] m_shadow = 12'h000;

    wire m_acc = wr_valid & m_ready;
    wire m_fe  = ((m_t % FRAME) == FRAME - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_ready  <= 1'b0;
            m_full   <= 1'b0;
            m_disp   <= 12'h000;
            m_shadow <= 12'h000;
            m_lz     <= blank_lz;
        end else if (m_active) begin
            if (m_fe && m_full) m_disp <= m_shadow;
            if (m_acc) m_shadow <= wr_data;
            m_full  <= m_acc | (m_full & ~m_fe);
            m_ready <= ~(m_acc | (m_full & ~m_fe));
            m_t     <= m_t + 1;
            if (((m_t + 1) % SLOT) == 0) m_lz <= blank_lz;
        end
    end

    initial begin : monitor
        int p, slot, off;
        forever begin
            @(negedge clk);
            if (m_active) begin
                p    = m_t % FRAME;
                slot = p / SLOT;
                off  = p % SLOT;
                chk("an", an, (off < BLANK_CYC) ? 0 : (4 >> slot));
                chk("frame_done", frame_done, (p == FRAME - 1) ? 1 : 0);
                chk("wr_ready", wr_ready, m_ready);
                if (m_t == 0)
                    chk("seg_after_reset", seg, 0);
                else if (m_t >= BLANK_CYC)
                    chk("seg", seg, model_seg(m_disp, 2 - slot, m_lz));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic lz);
        blank_lz = lz;
        wr_valid = 1'b0;
        rst      = 1'b1;
        tick(2);
        rst      = 1'b0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame_done: got timeout expected pulse within 100 cycles");
        end
    endtask

    typedef struct {
        logic [11:0] data;
        logic        lz;
        logic [6:0]  exp2;
        logic [6:0]  exp1;
        logic [6:0]  exp0;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        int cnt;
        bit prev_fd;
        int e_seen;

        vecs[0] = '{12'h007, 1'b1, 7'h00, 7'h00, 7'h07};
        vecs[1] = '{12'h070, 1'b1, 7'h00, 7'h07, 7'h3F};
        vecs[2] = '{12'h000, 1'b1, 7'h00, 7'h00, 7'h3F};
        vecs[3] = '{12'hABF, 1'b0, 7'h77, 7'h7C, 7'h71};
        vecs[4] = '{12'h123, 1'b0, 7'h06, 7'h5B, 7'h4F};
        vecs[5] = '{12'h100, 1'b1, 7'h06, 7'h3F, 7'h3F};
        vecs[6] = '{12'h000, 1'b0, 7'h3F, 7'h3F, 7'h3F};

        // Reset state and free-run with 0x000
        tick(1);
        do_reset(1'b0);
        chk("reset_an", an, 0);
        chk("reset_seg", seg, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_wr_ready", wr_ready, 0);
        tick(1);
        chk("wr_ready_after_reset", wr_ready, 1);

        wait_fd(ok);
        tick(1);
        cnt = 1;
        while (!frame_done && cnt < 100) begin
            tick(1);
            cnt++;
        end
        chk("frame_period", cnt, FRAME);

        // Write mid-frame; commit happens at frame end
        tick(12);
        wr_data  = 12'h123;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
        chk("wr_ready_drop", wr_ready, 0);
        wait_fd(ok);
        tick(1);
        chk("wr_ready_after_commit", wr_ready, 1);
        tick(6);
        chk("new_value_digit2", seg, 7'h06);
        tick(24);

        // Back-to-back writes with wr_valid held: second one stalls
        wr_data  = 12'h456;
        wr_valid = 1'b1;
        tick(1);
        wr_data  = 12'h789;
        prev_fd  = 1'b0;
        cnt      = 0;
        while (!wr_ready && cnt < 100) begin
            prev_fd = frame_done;
            tick(1);
            cnt++;
        end
        chk("stall_released_after_frame_done", prev_fd, 1);
        tick(1);
        wr_valid = 1'b0;
        chk("second_write_taken", wr_ready, 0);
        wait_fd(ok);
        tick(6);
        chk("789_digit2", seg, 7'h07);
        tick(10);
        chk("789_digit1", seg, 7'h7F);
        tick(40);

        // Vector table: glyphs and leading-zero blanking per digit
        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].lz);
            tick(1);
            wr_data  = vecs[i].data;
            wr_valid = 1'b1;
            tick(1);
            wr_valid = 1'b0;
            wait_fd(ok);
            tick(6);
            chk($sformatf("vec%0d_an2", i), an, 4);
            chk($sformatf("vec%0d_seg2", i), seg, vecs[i].exp2);
            tick(10);
            chk($sformatf("vec%0d_an1", i), an, 2);
            chk($sformatf("vec%0d_seg1", i), seg, vecs[i].exp1);
            tick(10);
            chk($sformatf("vec%0d_an0", i), an, 1);
            chk($sformatf("vec%0d_seg0", i), seg, vecs[i].exp0);
        end

        // Reset during DRIVE with a pending write discards the shadow
        do_reset(1'b0);
        tick(3);
        wr_data  = 12'hEEE;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
        cnt = 0;
        while (an == 3'b000 && cnt < 100) begin
            tick(1);
            cnt++;
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrun_reset_an", an, 0);
        chk("midrun_reset_seg", seg, 0);
        e_seen = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1);
            if (seg == 7'h79) e_seen++;
        end
        chk("pending_value_discarded", e_seen, 0);

        // Randomized traffic against the reference model
        do_reset(1'b0);
        tick(3);
        for (int i = 0; i < 900; i++) begin
            wr_valid = ($urandom_range(2) == 0);
            wr_data  = 12'($urandom);
            if ($urandom_range(40) == 0) blank_lz = ~blank_lz;
            tick(1);
        end
        wr_valid = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_display_scan_ctrl
`default_nettype wire
